// File: rtl/clock_hms_counter_if.sv
// Control and display bus of the HH:MM:SS counter.
// Macro: HMS_SUB_EN adds the i_sub (decrement button) signal.
// master: drives i_ena/i_add/i_mode[/i_sub], receives the fields and pulses.
// slave : the counter itself.
interface clock_hms_counter_if #(
  parameter int unsigned DW = 6
) ();
  logic          i_ena;
  logic          i_add;
  logic          i_mode;
`ifdef HMS_SUB_EN
  logic          i_sub;
`endif
  logic [DW-1:0] o_sec;
  logic [DW-1:0] o_min;
  logic [DW-1:0] o_hr;
  logic [1:0]    o_state;
  logic          o_tick;
  logic          o_day;

`ifdef HMS_SUB_EN
  modport master (output i_ena, i_add, i_mode, i_sub,
                  input  o_sec, o_min, o_hr, o_state, o_tick, o_day);
  modport slave  (input  i_ena, i_add, i_mode, i_sub,
                  output o_sec, o_min, o_hr, o_state, o_tick, o_day);
`else
  modport master (output i_ena, i_add, i_mode,
                  input  o_sec, o_min, o_hr, o_state, o_tick, o_day);
  modport slave  (input  i_ena, i_add, i_mode,
                  output o_sec, o_min, o_hr, o_state, o_tick, o_day);
`endif
endinterface

// File: rtl/clock_hms_counter.sv
// Time-of-day counter: prescaled seconds -> minutes -> hours cascade, with
// a set-mode FSM that lets a button adjust one field at a time.
// Macro: HMS_SUB_EN enables the i_sub decrement button.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - clock_hms_counter_if.slave: i_ena, i_add, i_mode, [i_sub] in;
//          o_sec, o_min, o_hr, o_state, o_tick, o_day out (all registered)
module clock_hms_counter #(
  parameter int unsigned TICK_DIV  = 2,
  parameter int unsigned SEC_LIMIT = 60,
  parameter int unsigned MIN_LIMIT = 60,
  parameter int unsigned HR_LIMIT  = 24,
  parameter int unsigned DW        = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_hms_counter_if.slave    bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] SEC_MAX = DW'(SEC_LIMIT - 1);
  localparam logic [DW-1:0] MIN_MAX = DW'(MIN_LIMIT - 1);
  localparam logic [DW-1:0] HR_MAX  = DW'(HR_LIMIT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pre,   w_pre_nxt;
  logic [DW-1:0] r_sec,   w_sec_nxt;
  logic [DW-1:0] r_min,   w_min_nxt;
  logic [DW-1:0] r_hr,    w_hr_nxt;
  logic          r_tick,  w_tick_nxt;
  logic          r_day,   w_day_nxt;
  logic          w_sub;
  logic          w_inc;
  logic          w_dec;

  function automatic logic [DW-1:0] inc_mod(input logic [DW-1:0] v,
                                            input logic [DW-1:0] vmax);
    return (v == vmax) ? '0 : v + DW'(1);
  endfunction

  function automatic logic [DW-1:0] dec_mod(input logic [DW-1:0] v,
                                            input logic [DW-1:0] vmax);
    return (v == '0) ? vmax : v - DW'(1);
  endfunction

`ifdef HMS_SUB_EN
  assign w_sub = bus.i_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Simultaneous add and subtract cancel each other.
  assign w_inc = bus.i_add & ~w_sub;
  assign w_dec = w_sub & ~bus.i_add;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pre   <= '0;
      r_sec   <= '0;
      r_min   <= '0;
      r_hr    <= '0;
      r_tick  <= 1'b0;
      r_day   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_sec   <= w_sec_nxt;
      r_min   <= w_min_nxt;
      r_hr    <= w_hr_nxt;
      r_tick  <= w_tick_nxt;
      r_day   <= w_day_nxt;
    end
  end

  // Next state: mode pulse beats field adjust, which beats the tick.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_hr_nxt    = r_hr;
    w_tick_nxt  = 1'b0;
    w_day_nxt   = 1'b0;

    if (bus.i_mode) begin
      // Prescaler is parked at zero whenever we are not running, so the
      // first tick after resuming takes a full TICK_DIV enables.
      w_pre_nxt = '0;
      case (r_state)
        RUN:     w_state_nxt = SET_HR;
        SET_HR:  w_state_nxt = SET_MIN;
        SET_MIN: w_state_nxt = SET_SEC;
        default: w_state_nxt = RUN;
      endcase
    end else begin
      case (r_state)
        RUN: begin
          if (bus.i_ena) begin
            if (r_pre == PRE_MAX) begin
              w_pre_nxt  = '0;
              w_tick_nxt = 1'b1;
              w_sec_nxt  = inc_mod(r_sec, SEC_MAX);
              if (r_sec == SEC_MAX) begin
                w_min_nxt = inc_mod(r_min, MIN_MAX);
                if (r_min == MIN_MAX) begin
                  w_hr_nxt  = inc_mod(r_hr, HR_MAX);
                  w_day_nxt = (r_hr == HR_MAX);
                end
              end
            end else begin
              w_pre_nxt = r_pre + PW'(1);
            end
          end
        end
        SET_HR: begin
          if (w_inc)      w_hr_nxt = inc_mod(r_hr, HR_MAX);
          else if (w_dec) w_hr_nxt = dec_mod(r_hr, HR_MAX);
        end
        SET_MIN: begin
          if (w_inc)      w_min_nxt = inc_mod(r_min, MIN_MAX);
          else if (w_dec) w_min_nxt = dec_mod(r_min, MIN_MAX);
        end
        default: begin
          if (w_inc)      w_sec_nxt = inc_mod(r_sec, SEC_MAX);
          else if (w_dec) w_sec_nxt = dec_mod(r_sec, SEC_MAX);
        end
      endcase
    end
  end

  assign bus.o_sec   = r_sec;
  assign bus.o_min   = r_min;
  assign bus.o_hr    = r_hr;
  assign bus.o_state = r_state;
  assign bus.o_tick  = r_tick;
  assign bus.o_day   = r_day;

endmodule

// File: doc/clock_hms_counter.md
# clock_hms_counter

Parametrised time-of-day counter for the clock datapath: seconds, minutes and hours fields cascaded with carry, advanced by a prescaled enable strobe. It also has a set-mode state machine that lets a single add (and optionally subtract) button adjust one field at a time. It sits between the enable/tick generator and the display formatting logic, and generalises the standalone hour counter to a full HH:MM:SS chain with configurable limits and tick rate.

## Interface
Parameters:
- TICK_DIV, 2: number of qualifying i_ena cycles per seconds increment; legal range 1..256.
- SEC_LIMIT, 60: seconds modulus; field counts 0..SEC_LIMIT-1.
- MIN_LIMIT, 60: minutes modulus.
- HR_LIMIT, 24: hours modulus.
- DW, 6: width of each field output; must satisfy 2^DW >= every LIMIT.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high; clears all state on the clock edge where it is high.
- i_ena  input  1  count strobe; level sampled each cycle.
- i_add  input  1  single-cycle button pulse; increments the selected field in set mode.
- i_mode  input  1  single-cycle pulse; advances the set-mode FSM.
- i_sub  input  1  single-cycle pulse; decrements the selected field. Present only with HMS_SUB_EN.
- o_sec  output  DW  seconds field.
- o_min  output  DW  minutes field.
- o_hr  output  DW  hours field.
- o_state  output  2  FSM state: RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3.
- o_tick  output  1  one-cycle pulse; high in the same cycle the new o_sec value from a tick first appears.
- o_day  output  1  one-cycle pulse; high when hours wrap HR_LIMIT-1 -> 0 due to a tick carry.

## Operation
- Reset values: o_sec, o_min, o_hr = 0; o_state = RUN; o_tick = o_day = 0; prescaler = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Prescaler:
  - Width $clog2(TICK_DIV), minimum 1 bit.
  - In RUN, each cycle with i_ena = 1 increments it. When it equals TICK_DIV-1 and i_ena = 1, it returns to 0 and a tick occurs.
  - With TICK_DIV = 1, every i_ena cycle is a tick.
  - Outside RUN the prescaler holds at 0.
- Tick cascade:
  - sec increments. At SEC_LIMIT-1 it wraps to 0 and carries into min.
  - min wraps at MIN_LIMIT-1 and carries into hr.
  - hr wraps at HR_LIMIT-1 to 0 and raises o_day.
  - All carries resolve in the same cycle: 23:59:59 -> 00:00:00 in one edge.
- FSM:
  - An i_mode pulse moves RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
  - Leaving SET_SEC clears the prescaler, so the first tick after resuming needs a full TICK_DIV qualifying i_ena cycles.
- Set mode:
  - i_add increments only the selected field, modulo its LIMIT, with no carry into other fields and no o_day.
  - In RUN, i_add and i_sub are ignored.
- Priority within one cycle: rst > i_mode > i_add/i_sub > tick.
  - i_mode together with i_add: state advances, add is dropped.
  - i_add together with i_sub: no field change.
- i_ena is ignored in set states. No time accrues while setting.

## Timing
- Tick latency: on the edge where the TICK_DIV-th qualifying i_ena is sampled, the fields update and o_tick is driven high. Both are visible in the following cycle.
- o_tick and o_day are high for exactly one cycle per event.
- i_add/i_sub/i_mode take effect on the sampling edge, so the field or state is visible in the next cycle. A held-high i_add increments once per cycle.
- Reset mid-operation: the edge with rst high clears everything, including a pending prescaler count and the set state. Outputs read reset values in the next cycle.

## Configuration
- HMS_SUB_EN defined:
  - i_sub port exists. In set states it decrements the selected field modulo its LIMIT (0 -> LIMIT-1), with no borrow into other fields.
  - Simultaneous i_add and i_sub cancel.
- HMS_SUB_EN undefined:
  - No i_sub port. Only increment is available; all other behaviour is identical.

## Test plan
- Reset then i_ena held high, TICK_DIV=2 -> o_sec reads 1 after 2 cycles, 2 after 4 cycles; o_tick pulses every 2nd cycle.
- Time preloaded to 23:59:59, one tick -> 00:00:00 in one cycle, with o_tick and o_day each high for one cycle.
- Three i_mode pulses, then i_add x5 in SET_SEC starting from sec=58 -> sec=3; min and hr unchanged; no o_day; a fourth i_mode returns o_state=0.
- In SET_HR with hr=23: i_add -> 0. With HMS_SUB_EN: i_sub at 0 -> 23, and i_add together with i_sub -> unchanged.
- i_mode and i_add asserted in the same RUN cycle -> o_state=1, all fields unchanged; i_ena high during SET states -> no tick.
- rst asserted mid-count at 12:34:56 with prescaler=1 -> next cycle all zero, o_state=0; the first subsequent tick needs 2 i_ena cycles.
